// File: rtl/io_responder_if.sv
// CPU-side IO bus between the core and io_responder: strobes, address and store data
// going in, captured switch snapshot and error pulse coming back.
interface io_responder_if;
    logic        io_read;
    logic        io_write;
    logic [31:0] addr_in;
    logic [31:0] wdata;
    logic [7:0]  io_rdata;
    logic [7:0]  io_rdata2;
    logic        negative;
    logic        data_valid;
    logic        addr_err;

    modport master (
        output io_read, io_write, addr_in, wdata,
        input  io_rdata, io_rdata2, negative, data_valid, addr_err
    );

    modport slave (
        input  io_read, io_write, addr_in, wdata,
        output io_rdata, io_rdata2, negative, data_valid, addr_err
    );
endinterface

// File: rtl/io_responder.sv
// Board IO responder: debounces switches/sign/button, snapshots the switches on a button
// press for the CPU, drives memory-mapped LEDs and flags illegal accesses.
module io_responder #(
    parameter int unsigned DEB_CYCLES = 20,
    parameter logic [23:0] IO_BASE    = 24'hFFFFFC
) (
    input  logic               clk,
    input  logic               rst,
    io_responder_if.slave      bus,
    input  logic [15:0]        sw_raw,
    input  logic               sw_neg_raw,
    input  logic               btn_raw,
    output logic [15:0]        led
);

    localparam int unsigned CntW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEB_CYCLES - 1);

    typedef enum logic {StIdle, StHeld} state_e;

    logic [15:0]     sw_meta_q, sw_sync_q, sw_deb_q, sw_deb_d;
    logic            neg_meta_q, neg_sync_q, neg_deb_q, neg_deb_d;
    logic            btn_meta_q, btn_sync_q, btn_deb_q, btn_deb_d;
    logic [CntW-1:0] sw_cnt_q, sw_cnt_d, neg_cnt_q, neg_cnt_d, btn_cnt_q, btn_cnt_d;
    logic            sw_load, neg_load, btn_load;

    state_e      state_q, state_d;
    logic        capture;
    logic [7:0]  rdata_q, rdata2_q;
    logic        negative_q, valid_q, err_q;
    logic [15:0] led_q;

    logic        in_win, both, wr_lo, wr_hi, rd_clr, acc_err;
    logic [7:0]  off;
    logic        unused_wdata;

    assign unused_wdata = ^bus.wdata[31:8];

    // Each group loads only after DEB_CYCLES consecutive cycles of disagreement.
    always_comb begin
        sw_load   = (sw_sync_q != sw_deb_q) && (sw_cnt_q == CntMax);
        sw_cnt_d  = ((sw_sync_q == sw_deb_q) || sw_load) ? '0 : sw_cnt_q + CntW'(1);
        sw_deb_d  = sw_load ? sw_sync_q : sw_deb_q;
        neg_load  = (neg_sync_q != neg_deb_q) && (neg_cnt_q == CntMax);
        neg_cnt_d = ((neg_sync_q == neg_deb_q) || neg_load) ? '0 : neg_cnt_q + CntW'(1);
        neg_deb_d = neg_load ? neg_sync_q : neg_deb_q;
        btn_load  = (btn_sync_q != btn_deb_q) && (btn_cnt_q == CntMax);
        btn_cnt_d = ((btn_sync_q == btn_deb_q) || btn_load) ? '0 : btn_cnt_q + CntW'(1);
        btn_deb_d = btn_load ? btn_sync_q : btn_deb_q;
    end

    // A load always flips the debounced button, so the synced value gives the edge direction.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (btn_load && btn_sync_q) begin
                    state_d = StHeld;
                    capture = 1'b1;
                end
            end
            StHeld: begin
                if (btn_load && !btn_sync_q) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        in_win  = (bus.addr_in[31:8] == IO_BASE);
        off     = bus.addr_in[7:0];
        both    = bus.io_read && bus.io_write;
        wr_lo   = !both && bus.io_write && in_win && (off == 8'h60);
        wr_hi   = !both && bus.io_write && in_win && (off == 8'h62);
        rd_clr  = !both && bus.io_read && in_win && ((off == 8'h70) || (off == 8'h72));
        acc_err = (bus.io_read || bus.io_write) && !(wr_lo || wr_hi || rd_clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
            sw_deb_q   <= '0;
            sw_cnt_q   <= '0;
            neg_meta_q <= 1'b0;
            neg_sync_q <= 1'b0;
            neg_deb_q  <= 1'b0;
            neg_cnt_q  <= '0;
            btn_meta_q <= 1'b0;
            btn_sync_q <= 1'b0;
            btn_deb_q  <= 1'b0;
            btn_cnt_q  <= '0;
            state_q    <= StIdle;
            rdata_q    <= '0;
            rdata2_q   <= '0;
            negative_q <= 1'b0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            led_q      <= '0;
        end else begin
            sw_meta_q  <= sw_raw;
            sw_sync_q  <= sw_meta_q;
            sw_deb_q   <= sw_deb_d;
            sw_cnt_q   <= sw_cnt_d;
            neg_meta_q <= sw_neg_raw;
            neg_sync_q <= neg_meta_q;
            neg_deb_q  <= neg_deb_d;
            neg_cnt_q  <= neg_cnt_d;
            btn_meta_q <= btn_raw;
            btn_sync_q <= btn_meta_q;
            btn_deb_q  <= btn_deb_d;
            btn_cnt_q  <= btn_cnt_d;
            state_q    <= state_d;
            err_q      <= acc_err;
            if (wr_lo) led_q[7:0]  <= bus.wdata[7:0];
            if (wr_hi) led_q[15:8] <= bus.wdata[7:0];
            // Capture outranks a clearing read on the same edge.
            if (capture) begin
                rdata_q    <= sw_deb_d[7:0];
                rdata2_q   <= sw_deb_d[15:8];
                negative_q <= neg_deb_d;
                valid_q    <= 1'b1;
            end else if (rd_clr) begin
                valid_q    <= 1'b0;
            end
        end
    end

    assign bus.io_rdata   = rdata_q;
    assign bus.io_rdata2  = rdata2_q;
    assign bus.negative   = negative_q;
    assign bus.data_valid = valid_q;
    assign bus.addr_err   = err_q;
    assign led            = led_q;

endmodule

// File: tb/tb_io_responder.sv
// Self-checking bench for io_responder with DEB_CYCLES=4: bus vector table plus
// hand-written debounce/capture/reset sequences, checked through an expectation queue.
module tb_io_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] sw_raw;
    logic        sw_neg_raw;
    logic        btn_raw;
    logic [15:0] led;

    io_responder_if bus ();

    io_responder #(
        .DEB_CYCLES (4),
        .IO_BASE    (24'hFFFFFC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .sw_raw     (sw_raw),
        .sw_neg_raw (sw_neg_raw),
        .btn_raw    (btn_raw),
        .led        (led)
    );

    always #5 clk = ~clk;

    // Observation word: {led, addr_err, data_valid, io_rdata, io_rdata2, negative}
    typedef struct {
        string       name;
        logic [34:0] obs;
    } sb_t;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [15:0] led;
        logic        err;
    } vec_t;

    sb_t  sb_q[$];
    vec_t vecs[12];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [34:0] obs_now();
        return {led, bus.addr_err, bus.data_valid, bus.io_rdata, bus.io_rdata2, bus.negative};
    endfunction

    function automatic logic [34:0] mk(input logic [15:0] l, input logic e, input logic v,
                                       input logic [7:0] r, input logic [7:0] r2,
                                       input logic n);
        return {l, e, v, r, r2, n};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string name, input logic [34:0] obs);
        sb_t e;
        e.name = name;
        e.obs  = obs;
        sb_q.push_back(e);
    endtask

    task automatic pop_check();
        sb_t e;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: got output with empty queue expected entry");
        end else begin
            e = sb_q.pop_front();
            chk(e.name, 64'(obs_now()), 64'(e.obs));
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] d);
        bus.io_read  = rd;
        bus.io_write = wr;
        bus.addr_in  = a;
        bus.wdata    = d;
    endtask

    // Waits for data_valid to rise; returns edge count or 0 if it never does.
    task automatic wait_capture(input int budget, output int lat);
        lat = 0;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (bus.data_valid && lat == 0) begin
                lat = i;
                pop_check();
            end
        end
        if (lat == 0) begin
            void'(sb_q.pop_front());
            checks++;
            errors++;
            $display("FAIL capture: got no data_valid within %0d cycles expected capture", budget);
        end
    endtask

    initial begin
        int lat;

        vecs[0]  = '{1'b0, 1'b1, 32'hFFFFFC60, 32'h000012F0, 16'h00F0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 32'hFFFFFC62, 32'h00000081, 16'h81F0, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 32'hFFFFFC60, 32'h00000055, 16'h81F0, 1'b1};
        vecs[3]  = '{1'b0, 1'b1, 32'h10010000, 32'h00000077, 16'h81F0, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 32'hFFFFFC60, 32'h00000099, 16'h81F0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 32'hFFFFFC70, 32'h00000033, 16'h81F0, 1'b1};
        vecs[6]  = '{1'b1, 1'b0, 32'hFFFFFC60, 32'h00000033, 16'h81F0, 1'b1};
        vecs[7]  = '{1'b0, 1'b1, 32'hFFFFFC61, 32'h00000033, 16'h81F0, 1'b1};
        vecs[8]  = '{1'b0, 1'b1, 32'hFFFFFD60, 32'h00000033, 16'h81F0, 1'b1};
        vecs[9]  = '{1'b1, 1'b0, 32'hFFFFFC72, 32'h00000000, 16'h81F0, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 32'hFFFFFC62, 32'hFFFFFF00, 16'h00F0, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 32'h00000000, 32'h00000000, 16'h00F0, 1'b0};

        rst        = 1'b1;
        sw_raw     = 16'h0000;
        sw_neg_raw = 1'b0;
        btn_raw    = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        tick();
        rst = 1'b0;
        chk("reset_state", 64'(obs_now()), 64'(0));

        foreach (vecs[i]) begin
            drive(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
            push($sformatf("vec%0d", i), mk(vecs[i].led, vecs[i].err, 1'b0, 8'h00, 8'h00, 1'b0));
            tick();
            drive(1'b0, 1'b0, 32'h0, 32'h0);
            pop_check();
        end

        // Button glitch of 3 cycles must not capture.
        sw_raw     = 16'hA53C;
        sw_neg_raw = 1'b1;
        repeat (8) tick();
        btn_raw = 1'b1;
        repeat (3) tick();
        btn_raw = 1'b0;
        repeat (10) tick();
        chk("glitch_no_capture", 64'(obs_now()), 64'(mk(16'h00F0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0)));

        // Clean press: capture exactly 6 edges after the raw edge.
        push("capture_a53c", mk(16'h00F0, 1'b0, 1'b1, 8'h3C, 8'hA5, 1'b1));
        btn_raw = 1'b1;
        wait_capture(10, lat);
        chk("capture_latency", 64'(lat), 64'd6);

        // Switch changes while held must not disturb the snapshot.
        sw_raw     = 16'hFFFF;
        sw_neg_raw = 1'b0;
        repeat (8) tick();
        chk("held_no_update", 64'(obs_now()), 64'(mk(16'h00F0, 1'b0, 1'b1, 8'h3C, 8'hA5, 1'b1)));
        btn_raw = 1'b0;
        repeat (8) tick();

        // Clearing read on the capture edge: capture wins, then a lone read clears.
        sw_raw = 16'h1234;
        repeat (8) tick();
        push("capture_vs_read", mk(16'h00F0, 1'b0, 1'b1, 8'h34, 8'h12, 1'b0));
        btn_raw = 1'b1;
        repeat (5) tick();
        drive(1'b1, 1'b0, 32'hFFFFFC70, 32'h0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        pop_check();
        push("read_clears", mk(16'h00F0, 1'b0, 1'b0, 8'h34, 8'h12, 1'b0));
        drive(1'b1, 1'b0, 32'hFFFFFC72, 32'h0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        pop_check();

        // Reset in HELD with LEDs lit, with a write strobe on the reset edge.
        drive(1'b0, 1'b1, 32'hFFFFFC60, 32'h000000FF);
        tick();
        drive(1'b0, 1'b1, 32'hFFFFFC62, 32'h000000FF);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        chk("led_ffff", 64'(led), 64'h0000_0000_0000_FFFF);
        rst = 1'b1;
        drive(1'b0, 1'b1, 32'hFFFFFC60, 32'h0000005A);
        tick();
        rst = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        chk("reset_in_held", 64'(obs_now()), 64'(0));
        push("recapture", mk(16'h0000, 1'b0, 1'b1, 8'h34, 8'h12, 1'b0));
        wait_capture(10, lat);
        chk("recapture_latency", 64'(lat - 1), 64'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no completion expected finish");
        $fatal(1, "timeout");
    end

endmodule
